// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus: stall/redirect control, instruction-memory write port,
// and the decoded IF/ID fields handed to the controller and datapath.
interface instr_fetch_stage_if #(
  parameter int ADDR_W = 6
);
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  logic [31:0]       instr;
  logic [5:0]        op_code;
  logic [5:0]        func;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic              instr_valid;
  logic [31:0]       pc_id;
  logic [31:0]       pc_plus4_id;
  logic [31:0]       pc;

  modport master (
    output stall, redirect, redirect_pc, imem_we, imem_waddr, imem_wdata,
    input  instr, op_code, func, rs, rt, rd, shamt, instr_valid,
           pc_id, pc_plus4_id, pc
  );

  modport slave (
    input  stall, redirect, redirect_pc, imem_we, imem_waddr, imem_wdata,
    output instr, op_code, func, rs, rt, rd, shamt, instr_valid,
           pc_id, pc_plus4_id, pc
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// MIPS fetch stage: PC, writable instruction memory and IF/ID register,
// with stall (hold) and redirect (load target and flush to a bubble).
module instr_fetch_stage #(
  parameter int          ADDR_W = 6,
  parameter logic [31:0] BUBBLE = 32'hFFFF_FFFF
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_stage_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       pc_q;
  logic [31:0]       instr_q;
  logic              valid_q;
  logic [31:0]       pc_id_q;
  logic [ADDR_W-1:0] fetch_idx;
  logic [31:0]       target_pc;

  assign fetch_idx = pc_q[ADDR_W+1:2];
  assign target_pc = bus.redirect_pc & 32'hFFFF_FFFC;

  // Memory is not reset, so it survives rst_n; a same-edge write is not seen by the fetch.
  always_ff @(posedge clk) begin
    if (bus.imem_we) begin
      mem[bus.imem_waddr] <= bus.imem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= 32'h0;
      instr_q <= BUBBLE;
      valid_q <= 1'b0;
      pc_id_q <= 32'h0;
    end else if (bus.redirect) begin
      pc_q    <= target_pc;
      instr_q <= BUBBLE;
      valid_q <= 1'b0;
    end else if (!bus.stall) begin
      pc_q    <= pc_q + 32'd4;
      instr_q <= mem[fetch_idx];
      valid_q <= 1'b1;
      pc_id_q <= pc_q;
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc_id       = pc_id_q;
  assign bus.pc_plus4_id = pc_id_q + 32'd4;
  assign bus.pc          = pc_q;

  assign bus.op_code = instr_q[31:26];
  assign bus.rs      = instr_q[25:21];
  assign bus.rt      = instr_q[20:16];
  assign bus.rd      = instr_q[15:11];
  assign bus.shamt   = instr_q[10:6];
  assign bus.func    = instr_q[5:0];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed fetch/stall/redirect/wrap/collision/reset
// vectors, a cycle-level reference model, and literal expectations.
module tb_instr_fetch_stage;

  localparam logic [31:0] BUBBLE = 32'hFFFF_FFFF;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  instr_fetch_stage_if #(.ADDR_W(6)) bus ();

  instr_fetch_stage #(.ADDR_W(6), .BUBBLE(BUBBLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: PC arithmetic in plain words, memory as a flat array.
  logic [31:0] m_mem [64];
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic [31:0] m_pc_id;

  always @(posedge clk) begin
    if (bus.imem_we) m_mem[bus.imem_waddr] <= bus.imem_wdata;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc    <= 32'h0;
      m_instr <= BUBBLE;
      m_valid <= 1'b0;
      m_pc_id <= 32'h0;
    end else if (bus.redirect) begin
      m_pc    <= (bus.redirect_pc / 4) * 4;
      m_instr <= BUBBLE;
      m_valid <= 1'b0;
    end else if (!bus.stall) begin
      m_instr <= m_mem[(m_pc / 4) % 64];
      m_valid <= 1'b1;
      m_pc_id <= m_pc;
      m_pc    <= m_pc + 32'd4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    check("model.instr", bus.instr, m_instr);
    check("model.valid", {31'b0, bus.instr_valid}, {31'b0, m_valid});
    check("model.pc_id", bus.pc_id, m_pc_id);
    check("model.pc_plus4_id", bus.pc_plus4_id, m_pc_id + 32'd4);
    check("model.pc", bus.pc, m_pc);
    check("model.fields", {bus.op_code, bus.rs, bus.rt, bus.rd, bus.shamt, bus.func}, m_instr);
  end

  task automatic apply_stimulus(input logic stall, input logic redirect, input logic [31:0] rpc,
                                input logic we, input logic [5:0] waddr, input logic [31:0] wdata);
    @(negedge clk);
    bus.stall       = stall;
    bus.redirect    = redirect;
    bus.redirect_pc = rpc;
    bus.imem_we     = we;
    bus.imem_waddr  = waddr;
    bus.imem_wdata  = wdata;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string tag, input logic [31:0] e_instr, input logic e_valid,
                              input logic [31:0] e_pc_id, input logic [31:0] e_pc);
    check($sformatf("%s.instr", tag), bus.instr, e_instr);
    check($sformatf("%s.valid", tag), {31'b0, bus.instr_valid}, {31'b0, e_valid});
    check($sformatf("%s.pc_id", tag), bus.pc_id, e_pc_id);
    check($sformatf("%s.pc", tag), bus.pc, e_pc);
  endtask

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    if (i == 0)      w = 32'h0000_0020;
    else if (i == 1) w = 32'h0000_0022;
    else if (i == 2) w = 32'h0000_0000;
    else             w = 32'hA000_0000 | (32'(i) << 8) | 32'(i);
    return w;
  endfunction

  initial begin
    rst_n           = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_we     = 1'b0;
    bus.imem_waddr  = 6'd0;
    bus.imem_wdata  = 32'h0;

    for (int i = 0; i < 64; i++) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 6'(i), init_word(i));
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
    step();
    check_output("reset", BUBBLE, 1'b0, 32'h0, 32'h0);
    check("reset.op_code", {26'b0, bus.op_code}, 32'h3F);
    check("reset.func", {26'b0, bus.func}, 32'h3F);
    check("reset.pc_plus4_id", bus.pc_plus4_id, 32'h4);

    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_output("fetch0", 32'h0000_0020, 1'b1, 32'h0, 32'h4);
    check("fetch0.op_code", {26'b0, bus.op_code}, 32'h00);
    check("fetch0.func", {26'b0, bus.func}, 32'h20);
    step();
    check_output("fetch1", 32'h0000_0022, 1'b1, 32'h4, 32'h8);
    check("fetch1.func", {26'b0, bus.func}, 32'h22);

    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
    for (int n = 0; n < 3; n++) begin
      step();
      check_output($sformatf("stall%0d", n), 32'h0000_0022, 1'b1, 32'h4, 32'h8);
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
    step();
    check_output("unstall", 32'h0000_0000, 1'b1, 32'h8, 32'hC);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rst", BUBBLE, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_output("post_rst", 32'h0000_0020, 1'b1, 32'h0, 32'h4);

    apply_stimulus(1'b1, 1'b1, 32'h0000_0013, 1'b0, 6'd0, 32'h0);
    step();
    check_output("redir_stall", BUBBLE, 1'b0, 32'h0, 32'h10);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
    step();
    check_output("redir_target", 32'hA000_0404, 1'b1, 32'h10, 32'h14);

    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 6'd5, 32'hDEAD_BEEF);
    step();
    check_output("collide_old", 32'hA000_0505, 1'b1, 32'h14, 32'h18);
    apply_stimulus(1'b0, 1'b1, 32'h0000_0014, 1'b0, 6'd0, 32'h0);
    step();
    check_output("redir20_bubble", BUBBLE, 1'b0, 32'h14, 32'h14);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
    step();
    check_output("collide_new", 32'hDEAD_BEEF, 1'b1, 32'h14, 32'h18);

    apply_stimulus(1'b0, 1'b1, 32'h0000_00FC, 1'b0, 6'd0, 32'h0);
    step();
    check_output("wrap_bubble", BUBBLE, 1'b0, 32'h14, 32'hFC);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
    step();
    check_output("wrap63", 32'hA000_3F3F, 1'b1, 32'hFC, 32'h100);
    step();
    check_output("wrap0", 32'h0000_0020, 1'b1, 32'h100, 32'h104);

    apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 6'd0, 32'h0);
    step();
    check_output("top_bubble", BUBBLE, 1'b0, 32'h100, 32'hFFFF_FFFC);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
    step();
    check_output("top63", 32'hA000_3F3F, 1'b1, 32'hFFFF_FFFC, 32'h0);
    check("top63.pc_plus4_id", bus.pc_plus4_id, 32'h0);
    step();
    check_output("top_wrap0", 32'h0000_0020, 1'b1, 32'h0, 32'h4);

    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

- Fetch stage of the single-cycle-decode MIPS datapath.
- Holds the program counter and a small writable instruction memory, and registers the fetched word into an IF/ID pipeline register.
- Drives `op_code` and `func` straight into the instruction controller, plus register fields and PC values for the datapath.
- Supports stall (hold) and redirect (branch/jump with flush).

## Interface

Parameters:
- `ADDR_W`, default 6: instruction-memory word-address width; depth = 2^ADDR_W words.
- `BUBBLE`, default 32'hFFFF_FFFF: word loaded into IF/ID on reset/flush. The opcode/func pair 111111/111111 decodes to control 00000, so the bubble causes no RF, DM or IM side effects.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `stall` in 1: hold PC and IF/ID contents.
- `redirect` in 1: load `redirect_pc` into PC and flush IF/ID.
- `redirect_pc` in 32: target byte address; bits [1:0] are ignored (forced 00).
- `imem_we` in 1: instruction-memory write enable.
- `imem_waddr` in ADDR_W: word address to write.
- `imem_wdata` in 32: word to write.
- `instr` out 32: IF/ID instruction word.
- `op_code` out 6: `instr[31:26]`.
- `func` out 6: `instr[5:0]`.
- `rs`, `rt`, `rd` out 5 each: `instr[25:21]`, `[20:16]`, `[15:11]`.
- `shamt` out 5: `instr[10:6]`.
- `instr_valid` out 1: IF/ID holds a real fetched instruction.
- `pc_id` out 32: byte address of the instruction in IF/ID.
- `pc_plus4_id` out 32: `pc_id + 4`.
- `pc` out 32: current fetch PC.

## Operation

- State:
  - `pc` (32 b).
  - IF/ID register: `instr`, `instr_valid`, `pc_id`.
  - Memory array of 2^ADDR_W × 32. The array is not reset; its contents are undefined until written.
- Fetch index is `pc[ADDR_W+1:2]`. Upper PC bits are ignored, so fetch aliases and wraps modulo the memory depth.
- Every rising edge, priority is highest first:
  1. `redirect`:
     - `pc <= {redirect_pc[31:2],2'b00}`.
     - `instr <= BUBBLE`, `instr_valid <= 0`.
     - `pc_id` is unchanged.
     - Redirect wins over a simultaneous `stall`.
  2. `stall`: `pc`, `instr`, `instr_valid` and `pc_id` all hold.
  3. Otherwise:
     - `instr <= mem[pc index]`.
     - `instr_valid <= 1`.
     - `pc_id <= pc`.
     - `pc <= pc + 4`, wrapping modulo 2^32.
- Memory write:
  - When `imem_we` is high, `mem[imem_waddr] <= imem_wdata` at the edge.
  - Writes are independent of stall and redirect.
  - A write and a fetch to the same word in the same cycle return the old data; the new data is visible from the next cycle.
- All field outputs are pure wiring slices of `instr`; no other logic sits between the IF/ID register and the controller.

## Timing

- Reset (asynchronous on `rst_n` low, takes effect immediately, independent of `clk`):
  - `pc = 0`, `instr = BUBBLE`, `instr_valid = 0`, `pc_id = 0`.
  - Derived outputs follow: `op_code = 111111`, `func = 111111`, `pc_plus4_id = 4`.
- Latency: a word at PC address A appears on `instr` one edge after `pc == A` in a non-stall, non-redirect cycle. Throughput is one instruction per cycle.
- First edge after `rst_n` rises: `instr = mem[0]`, `instr_valid = 1`, `pc = 4`.
- Redirect penalty: exactly one bubble cycle. The target instruction appears on the second edge after `redirect` is sampled high, if neither edge is stalled.
- Stall held N cycles: outputs are frozen for N cycles, then resume with no instruction lost or duplicated.
- Reset asserted mid-stream discards the IF/ID contents and PC immediately. Memory contents are preserved across reset.

## Test plan

- Reset/sequential fetch:
  - Stimulus: preload `mem[0..2] = 32'h0000_0020, 32'h0000_0022, 32'h0000_0000`; release reset.
  - Response: on successive edges, `{op_code,func}` = 000000/100000, 000000/100010, 000000/000000; `instr_valid = 1`; `pc_id` = 0, 4, 8.
- Stall:
  - Stimulus: assert `stall` for 3 cycles while `instr = mem[1]`.
  - Response: `instr`, `pc_id = 4` and `pc = 8` hold for 3 cycles; after release, `mem[2]` appears next.
- Redirect with simultaneous stall:
  - Stimulus: `redirect = 1`, `stall = 1`, `redirect_pc = 32'h0000_0013`.
  - Response:
    - Next edge: `pc = 32'h10`, `instr = 32'hFFFF_FFFF`, `instr_valid = 0`.
    - Following edge: `instr = mem[4]`, `pc_id = 32'h10`.
- Wrap:
  - Stimulus: `ADDR_W = 6`, redirect to `32'h0000_00FC`.
  - Response: fetches `mem[63]`, then `mem[0]` with `pc_id = 32'h100`.
- Write/read collision:
  - Stimulus: write `mem[5] = 32'hDEAD_BEEF` in the same cycle that `pc = 20` is fetched.
  - Response: the old `mem[5]` is returned. A later redirect to 20 returns `32'hDEAD_BEEF`.
- Asynchronous reset mid-stream:
  - Stimulus: drop `rst_n` between clock edges while `pc = 12`.
  - Response: `pc = 0`, `instr_valid = 0` and `instr = BUBBLE` immediately, without waiting for an edge.
